// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP TX packet arbiter and related stream muxes.
// Holds AXIS width defaults, arbiter state encoding and the packed-slice helper.
package udp_arb_pkg;

    localparam int AXIS_TDATA_WIDTH = 512;
    localparam int AXIS_TKEEP_WIDTH = 64;
    localparam int AXIS_TUSER_WIDTH = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Low bit position of lane idx inside a flattened per-source bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/udp_tx_pkt_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: scans upward from last_grant+1 with wrap.
// Shared between the TX arbiter and the RX demux.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic               o_grant_valid,
    output logic [IDX_W-1:0]   o_grant_idx
);

    // Walk offsets from farthest to nearest so the closest requester after
    // last_grant is the final (winning) assignment.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j == (int'(i_last_grant) + off) % NUM_REQ) && i_req[j]) begin
                    o_grant_valid = 1'b1;
                    o_grant_idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/udp_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXIS sources onto the UDP TX path,
// with a programmable inter-packet gap and free-running perf counters.
module udp_tx_pkt_arbiter
    import udp_arb_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH,
    parameter int TKEEP_WIDTH = AXIS_TKEEP_WIDTH,
    parameter int TUSER_WIDTH = AXIS_TUSER_WIDTH,
    parameter int GAP_WIDTH   = 16
) (
    input  logic                           udp_clk,
    input  logic                           udp_reset,
    input  logic                           arb_enable,
    input  logic [GAP_WIDTH-1:0]           pkt_gap_cycles,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC*TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_SRC*TUSER_WIDTH-1:0] s_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]         m_axis_tuser,
    output logic [$clog2(NUM_SRC)-1:0]     cur_grant,
    output logic                           busy,
    output logic [31:0]                    pkt_count,
    output logic [31:0]                    beat_count
);

    localparam int IDX_W = $clog2(NUM_SRC);

    arb_state_t           r_state;
    logic [IDX_W-1:0]     r_cur_grant;
    logic [IDX_W-1:0]     r_last_grant;
    logic [GAP_WIDTH-1:0] r_gap_cnt;
    logic [31:0]          r_pkt_count;
    logic [31:0]          r_beat_count;

    logic                 w_grant_valid;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_busy;
    logic                 w_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_SRC)
    ) u_rr_arbiter (
        .i_req         (s_axis_tvalid),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_busy = (r_state == BUSY);

    // Zero-latency passthrough of the granted lane; handshakes are gated off outside BUSY.
    always_comb begin
        w_sel_valid   = 1'b0;
        w_sel_last    = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_cur_grant == IDX_W'(i)) begin
                w_sel_valid      = s_axis_tvalid[i];
                w_sel_last       = s_axis_tlast[i];
                m_axis_tdata     = s_axis_tdata[slice_lo(i, TDATA_WIDTH) +: TDATA_WIDTH];
                m_axis_tkeep     = s_axis_tkeep[slice_lo(i, TKEEP_WIDTH) +: TKEEP_WIDTH];
                m_axis_tuser     = s_axis_tuser[slice_lo(i, TUSER_WIDTH) +: TUSER_WIDTH];
                s_axis_tready[i] = w_busy & m_axis_tready;
            end
        end
        m_axis_tvalid = w_busy & w_sel_valid;
        m_axis_tlast  = w_busy & w_sel_last;
    end

    assign w_hs = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge udp_clk) begin
        if (udp_reset) begin
            r_state      <= IDLE;
            r_cur_grant  <= '0;
            r_last_grant <= IDX_W'(NUM_SRC - 1);
            r_gap_cnt    <= '0;
            r_pkt_count  <= '0;
            r_beat_count <= '0;
        end else begin
            if (w_hs) begin
                r_beat_count <= r_beat_count + 32'd1;
            end
            case (r_state)
                IDLE: begin
                    if (arb_enable && w_grant_valid) begin
                        r_cur_grant <= w_grant_idx;
                        r_state     <= BUSY;
                    end
                end
                // Grant is held through tvalid stalls; only tlast releases it.
                BUSY: begin
                    if (w_hs && m_axis_tlast) begin
                        r_pkt_count  <= r_pkt_count + 32'd1;
                        r_last_grant <= r_cur_grant;
                        if (pkt_gap_cycles == '0) begin
                            r_state <= IDLE;
                        end else begin
                            r_gap_cnt <= pkt_gap_cycles;
                            r_state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
                    if (r_gap_cnt == GAP_WIDTH'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cur_grant  = r_cur_grant;
    assign busy       = w_busy;
    assign pkt_count  = r_pkt_count;
    assign beat_count = r_beat_count;

endmodule

// File: tb/tb_udp_tx_pkt_arbiter.sv
// Self-checking bench for udp_tx_pkt_arbiter (NUM_SRC=2): cycle vector table plus
// hand-written sequences for gap, backpressure, enable and mid-packet reset.
module tb_udp_tx_pkt_arbiter;

    logic          udp_clk = 1'b0;
    logic          udp_reset;
    logic          arb_enable;
    logic [15:0]   pkt_gap_cycles;
    logic [1:0]    s_axis_tvalid;
    logic [1:0]    s_axis_tready;
    logic [1:0]    s_axis_tlast;
    logic [1023:0] s_axis_tdata;
    logic [127:0]  s_axis_tkeep;
    logic [1:0]    s_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [511:0]  m_axis_tdata;
    logic [63:0]   m_axis_tkeep;
    logic [0:0]    m_axis_tuser;
    logic [0:0]    cur_grant;
    logic          busy;
    logic [31:0]   pkt_count;
    logic [31:0]   beat_count;

    udp_tx_pkt_arbiter #(.NUM_SRC(2)) dut (
        .udp_clk        (udp_clk),
        .udp_reset      (udp_reset),
        .arb_enable     (arb_enable),
        .pkt_gap_cycles (pkt_gap_cycles),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .cur_grant      (cur_grant),
        .busy           (busy),
        .pkt_count      (pkt_count),
        .beat_count     (beat_count)
    );

    always #5 udp_clk = ~udp_clk;

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic [1:0] l;
        logic       mv;
        logic       ml;
        logic [1:0] rdy;
        logic       bsy;
        logic       g;
        logic       chk;
        int         pkt;
        int         beat;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl[NV];

    int checks = 0;
    int errors = 0;

    int          plen[2];
    int          bi[2];
    int          pn[2];
    int          pmax[2];
    logic [1:0]  dropMask;
    logic        smpBusy;
    logic        smpGrant;
    logic [31:0] got[$];
    logic [31:0] expQ[$];
    int          gapQ[$];
    int          idleRun;
    bit          sawLast;

    function automatic vec_t mk(logic rst, logic [1:0] v, logic [1:0] l, logic mv, logic ml,
                                logic [1:0] rdy, logic bsy, logic g, logic chk, int pkt, int beat);
        vec_t r;
        r.rst = rst; r.v = v; r.l = l; r.mv = mv; r.ml = ml; r.rdy = rdy;
        r.bsy = bsy; r.g = g; r.chk = chk; r.pkt = pkt; r.beat = beat;
        return r;
    endfunction

    // Source payload model: {user, keep[7:0], data[15:0]} for a given source, packet and beat.
    function automatic logic [31:0] expTag(int s, int p, int b);
        return {7'd0, 1'(s), 8'(b) ^ 8'h5A, 4'(s), 4'(p), 8'(b)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveSources();
        logic [31:0] t;
        for (int s = 0; s < 2; s++) begin
            t = expTag(s, pn[s], bi[s]);
            s_axis_tvalid[s]          = (pn[s] < pmax[s]) & ~dropMask[s];
            s_axis_tlast[s]           = (bi[s] == plen[s] - 1);
            s_axis_tdata[s*512 +: 512] = {496'd0, t[15:0]};
            s_axis_tkeep[s*64 +: 64]   = {56'd0, t[23:16]};
            s_axis_tuser[s]            = t[24];
        end
    endtask

    // One clock: drive sources, sample at negedge, advance the source model on handshakes.
    task automatic applyStimulus();
        logic [1:0] hs;
        driveSources();
        @(negedge udp_clk);
        hs       = s_axis_tvalid & s_axis_tready;
        smpBusy  = busy;
        smpGrant = cur_grant[0];
        if (m_axis_tvalid && m_axis_tready) begin
            got.push_back({7'd0, m_axis_tuser, m_axis_tkeep[7:0], m_axis_tdata[15:0]});
            if (sawLast) gapQ.push_back(idleRun);
            sawLast = m_axis_tlast;
            idleRun = 0;
        end else begin
            idleRun++;
        end
        @(posedge udp_clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (hs[s]) begin
                if (bi[s] == plen[s] - 1) begin
                    bi[s] = 0;
                    pn[s]++;
                end else begin
                    bi[s]++;
                end
            end
        end
    endtask

    task automatic resetDut();
        udp_reset      = 1'b1;
        arb_enable     = 1'b1;
        m_axis_tready  = 1'b1;
        pkt_gap_cycles = 16'd0;
        s_axis_tvalid  = '0;
        s_axis_tlast   = '0;
        s_axis_tdata   = '0;
        s_axis_tkeep   = '0;
        s_axis_tuser   = '0;
        dropMask       = '0;
        for (int s = 0; s < 2; s++) begin
            plen[s] = 1; bi[s] = 0; pn[s] = 0; pmax[s] = 0;
        end
        got.delete();
        expQ.delete();
        gapQ.delete();
        idleRun = 0;
        sawLast = 0;
        repeat (2) @(posedge udp_clk);
        #1;
        udp_reset = 1'b0;
    endtask

    task automatic compareStream(input string name);
        checkOutput({name, "_len"}, got.size(), expQ.size());
        for (int i = 0; i < got.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s_beat%0d", name, i), got[i], expQ[i]);
    endtask

    initial begin
        // Single 4-beat packet on src0, then both sources alternating 3-beat packets.
        tbl[0]  = mk(0, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 2'b01, 2'b00, 1, 0, 2'b01, 1, 0, 1, 0, 0);
        tbl[2]  = mk(0, 2'b01, 2'b00, 1, 0, 2'b01, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 2'b01, 2'b00, 1, 0, 2'b01, 1, 0, 1, 0, 2);
        tbl[4]  = mk(0, 2'b01, 2'b01, 1, 1, 2'b01, 1, 0, 1, 0, 3);
        tbl[5]  = mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 1, 1, 4);
        tbl[6]  = mk(1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0);
        tbl[8]  = mk(0, 2'b11, 2'b00, 1, 0, 2'b01, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 2'b11, 2'b00, 1, 0, 2'b01, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 2'b11, 2'b01, 1, 1, 2'b01, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1, 1, 3);
        tbl[12] = mk(0, 2'b11, 2'b00, 1, 0, 2'b10, 1, 1, 0, 0, 0);
        tbl[13] = mk(0, 2'b11, 2'b00, 1, 0, 2'b10, 1, 1, 0, 0, 0);
        tbl[14] = mk(0, 2'b11, 2'b10, 1, 1, 2'b10, 1, 1, 0, 0, 0);
        tbl[15] = mk(0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2, 6);
        tbl[16] = mk(0, 2'b11, 2'b00, 1, 0, 2'b01, 1, 0, 0, 0, 0);
        tbl[17] = mk(0, 2'b11, 2'b00, 1, 0, 2'b01, 1, 0, 0, 0, 0);
        tbl[18] = mk(0, 2'b11, 2'b01, 1, 1, 2'b01, 1, 0, 0, 0, 0);
        tbl[19] = mk(0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 1, 3, 9);
        tbl[20] = mk(0, 2'b11, 2'b00, 1, 0, 2'b10, 1, 1, 1, 3, 9);
        tbl[21] = mk(1, 2'b10, 2'b00, 1, 0, 2'b10, 1, 1, 0, 0, 0);
        tbl[22] = mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0);

        resetDut();
        checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_mlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_grant", 32'(cur_grant), 32'd0);
        checkOutput("rst_pkt", pkt_count, 32'd0);
        checkOutput("rst_beat", beat_count, 32'd0);

        for (int i = 0; i < NV; i++) begin
            udp_reset    = tbl[i].rst;
            s_axis_tvalid = tbl[i].v;
            s_axis_tlast  = tbl[i].l;
            s_axis_tdata  = '0;
            s_axis_tdata[15:0]    = 16'hA000 + 16'(i);
            s_axis_tdata[512 +: 16] = 16'hB000 + 16'(i);
            @(negedge udp_clk);
            checkOutput($sformatf("v%0d_mvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].mv));
            checkOutput($sformatf("v%0d_mlast", i), 32'(m_axis_tlast), 32'(tbl[i].ml));
            checkOutput($sformatf("v%0d_tready", i), 32'(s_axis_tready), 32'(tbl[i].rdy));
            checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            if (tbl[i].bsy)
                checkOutput($sformatf("v%0d_grant", i), 32'(cur_grant), 32'(tbl[i].g));
            if (tbl[i].mv)
                checkOutput($sformatf("v%0d_data", i), 32'(m_axis_tdata[15:0]),
                            32'(tbl[i].g ? 16'hB000 + 16'(i) : 16'hA000 + 16'(i)));
            if (tbl[i].chk) begin
                checkOutput($sformatf("v%0d_pkt", i), pkt_count, 32'(tbl[i].pkt));
                checkOutput($sformatf("v%0d_beat", i), beat_count, 32'(tbl[i].beat));
            end
            @(posedge udp_clk);
            #1;
        end
        udp_reset = 1'b0;

        // Gap of 5 after every 2-beat packet from src1: 5 gap cycles plus 1 IDLE cycle.
        resetDut();
        pkt_gap_cycles = 16'd5;
        plen[1] = 2;
        pmax[1] = 4;
        repeat (37) applyStimulus();
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 2; b++) expQ.push_back(expTag(1, p, b));
        compareStream("gap");
        checkOutput("gap_count", gapQ.size(), 32'd3);
        for (int i = 0; i < gapQ.size(); i++)
            checkOutput($sformatf("gap_idle%0d", i), gapQ[i], 32'd6);
        checkOutput("gap_pkt", pkt_count, 32'd4);
        checkOutput("gap_beat", beat_count, 32'd8);

        // Downstream backpressure toggling plus a 3-cycle tvalid stall on src0.
        resetDut();
        plen[0] = 8;
        pmax[0] = 1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            m_axis_tready = (cyc % 2 == 0);
            dropMask      = (cyc >= 4 && cyc <= 6) ? 2'b01 : 2'b00;
            applyStimulus();
            if (cyc == 5) begin
                checkOutput("stall_busy", 32'(smpBusy), 32'd1);
                checkOutput("stall_grant", 32'(smpGrant), 32'd0);
            end
        end
        m_axis_tready = 1'b1;
        dropMask      = '0;
        for (int b = 0; b < 8; b++) expQ.push_back(expTag(0, 0, b));
        compareStream("bp");
        checkOutput("bp_beat", beat_count, 32'd8);
        checkOutput("bp_pkt", pkt_count, 32'd1);

        // arb_enable dropped during a src0 packet; src1 must win once enable returns.
        resetDut();
        plen[0] = 4; plen[1] = 4;
        pmax[0] = 2; pmax[1] = 1;
        for (int cyc = 0; cyc < 26; cyc++) begin
            arb_enable = !(cyc >= 2 && cyc < 12);
            applyStimulus();
            if (cyc == 8) checkOutput("en_off_busy8", 32'(smpBusy), 32'd0);
            if (cyc == 11) begin
                checkOutput("en_off_busy11", 32'(smpBusy), 32'd0);
                checkOutput("en_off_pkt", pkt_count, 32'd1);
            end
            if (cyc == 13) begin
                checkOutput("en_on_busy", 32'(smpBusy), 32'd1);
                checkOutput("en_on_grant", 32'(smpGrant), 32'd1);
            end
        end
        for (int b = 0; b < 4; b++) expQ.push_back(expTag(0, 0, b));
        for (int b = 0; b < 4; b++) expQ.push_back(expTag(1, 0, b));
        for (int b = 0; b < 4; b++) expQ.push_back(expTag(0, 1, b));
        compareStream("en");
        checkOutput("en_pkt", pkt_count, 32'd3);
        checkOutput("en_beat", beat_count, 32'd12);

        // Reset on the 2nd beat aborts the packet and clears everything.
        resetDut();
        plen[0] = 4;
        pmax[0] = 1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            if (cyc == 2) udp_reset = 1'b1;
            applyStimulus();
        end
        udp_reset = 1'b0;
        checkOutput("mrst_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("mrst_mvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("mrst_busy", 32'(busy), 32'd0);
        checkOutput("mrst_pkt", pkt_count, 32'd0);
        checkOutput("mrst_beat", beat_count, 32'd0);
        pmax[0] = 0;
        plen[1] = 2;
        pmax[1] = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("mrst_busy_src1", 32'(smpBusy), 32'd1);
        checkOutput("mrst_grant_src1", 32'(smpGrant), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
